// File: rtl/nbbpu_mem_if.sv
// Single shared memory port of the NBBPU core, carrying both instruction fetch and load/store traffic.
`timescale 1ns/1ps
interface nbbpu_mem_if;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/nbbpu_controller.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the NBBPU core.
// Define NBBPU_CTRL_HALT_EN to make op 1011 stop the core in a HALT state until reset.
`timescale 1ns/1ps
module nbbpu_controller #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   nbbpu_mem_if.master        mem,
   output logic [15:0]        instruction,
   output logic [15:0]        PC,
   output logic [15:0]        read_data,
   output logic [3:0]         x_sel,
   output logic [3:0]         y_sel,
   output logic [3:0]         z_sel,
   input  logic [15:0]        X,
   input  logic [15:0]        Y,
   input  logic [15:0]        Z,
   output logic               reg_we,
   output logic               halted
);

`ifdef NBBPU_CTRL_HALT_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_HALT
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK
   } state_t;
`endif

   state_t      state;
   logic [3:0]  op;
   logic        is_mem;
   logic        is_store;
   logic        wb_reg_we;
   logic [15:0] next_pc;
   logic        unused_z;

   assign op       = instruction[15:12];
   assign is_mem   = (op == 4'hC) || (op == 4'hD);
   assign is_store = (op == 4'hD);
   assign unused_z = ^Z[15:1];

   // Byte-set ops modify their destination in place, so port X reads rz instead of rx.
   always_comb begin
      x_sel = instruction[11:8];
      if ((op == 4'hE) || (op == 4'hF)) begin
         x_sel = instruction[3:0];
      end
   end

   assign y_sel = instruction[7:4];
   assign z_sel = instruction[3:0];

   always_comb begin
      wb_reg_we = 1'b1;
      case (op)
         4'h9, 4'hA, 4'hB, 4'hD: wb_reg_we = 1'b0;
         default:                wb_reg_we = 1'b1;
      endcase
   end

   // Jump always redirects; conditional branches redirect when the ALU reports the condition in Z[0].
   always_comb begin
      next_pc = PC + 16'd1;
      if (op == 4'h8) begin
         next_pc = X;
      end else if (((op == 4'h9) || (op == 4'hA)) && Z[0]) begin
         next_pc = X;
      end
   end

`ifndef NBBPU_CTRL_HALT_EN
   assign halted = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         PC            <= RESET_PC;
         instruction   <= 16'h0000;
         read_data     <= 16'h0000;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= 16'h0000;
         mem.mem_wdata <= 16'h0000;
         reg_we        <= 1'b0;
`ifdef NBBPU_CTRL_HALT_EN
         halted        <= 1'b0;
`endif
      end else begin
         reg_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run) begin
                  state        <= S_FETCH;
                  mem.mem_req  <= 1'b1;
                  mem.mem_we   <= 1'b0;
                  mem.mem_addr <= PC;
               end
            end
            S_FETCH: begin
               if (mem.mem_ack) begin
                  instruction <= mem.mem_rdata;
                  mem.mem_req <= 1'b0;
                  state       <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               if (is_mem) begin
                  state         <= S_MEMORY;
                  mem.mem_req   <= 1'b1;
                  mem.mem_we    <= is_store;
                  mem.mem_addr  <= X;
                  mem.mem_wdata <= Y;
`ifdef NBBPU_CTRL_HALT_EN
               end else if (op == 4'hB) begin
                  state  <= S_HALT;
                  halted <= 1'b1;
`endif
               end else begin
                  state  <= S_WRITEBACK;
                  reg_we <= wb_reg_we;
               end
            end
            S_MEMORY: begin
               if (mem.mem_ack) begin
                  if (!is_store) begin
                     read_data <= mem.mem_rdata;
                  end
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  state       <= S_WRITEBACK;
                  reg_we      <= wb_reg_we;
               end
            end
            S_WRITEBACK: begin
               PC <= next_pc;
               if (run) begin
                  state        <= S_FETCH;
                  mem.mem_req  <= 1'b1;
                  mem.mem_we   <= 1'b0;
                  mem.mem_addr <= next_pc;
               end else begin
                  state <= S_IDLE;
               end
            end
`ifdef NBBPU_CTRL_HALT_EN
            S_HALT: begin
               state <= S_HALT;
            end
`endif
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nbbpu_controller.sv
// Randomized bench for nbbpu_controller: a cycle-accurate memory responder with wait states
// and an instruction-level reference model of PC, register writes and memory accesses.
`timescale 1ns/1ps
module tb_nbbpu_controller;
   logic        clock;
   logic        reset;
   logic        run;
   logic [15:0] instruction;
   logic [15:0] PC;
   logic [15:0] read_data;
   logic [3:0]  x_sel;
   logic [3:0]  y_sel;
   logic [3:0]  z_sel;
   logic [15:0] X;
   logic [15:0] Y;
   logic [15:0] Z;
   logic        reg_we;
   logic        halted;

   int          checks;
   int          errors;
   logic [15:0] exp_pc;

   nbbpu_mem_if mem_bus();

   nbbpu_controller #(.RESET_PC(16'h0000)) dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .mem         (mem_bus),
      .instruction (instruction),
      .PC          (PC),
      .read_data   (read_data),
      .x_sel       (x_sel),
      .y_sel       (y_sel),
      .z_sel       (z_sel),
      .X           (X),
      .Y           (Y),
      .Z           (Z),
      .reg_we      (reg_we),
      .halted      (halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Executes one instruction in lock-step; entry is one cycle before the first FETCH sample.
   task automatic apply_stimulus(input logic [15:0] instr, input logic [15:0] xv, input logic [15:0] yv,
                                 input logic [15:0] zv, input logic [15:0] ld, input int fw, input int mw,
                                 input logic next_run);
      logic [3:0]  op;
      logic        exp_we;
      logic        mem_op;
      logic        store;
      logic [3:0]  exp_x;
      op     = instr[15:12];
      mem_op = (op == 4'hC) || (op == 4'hD);
      store  = (op == 4'hD);
      exp_we = (op <= 4'h8) || (op == 4'hC) || (op == 4'hE) || (op == 4'hF);
      exp_x  = ((op == 4'hE) || (op == 4'hF)) ? instr[3:0] : instr[11:8];

      for (int w = 0; w <= fw; w++) begin
         @(negedge clock);
         check_output("fetch_req", mem_bus.mem_req, 1);
         check_output("fetch_addr", mem_bus.mem_addr, exp_pc);
         check_output("fetch_we", mem_bus.mem_we, 0);
         mem_bus.mem_ack   = (w == fw);
         mem_bus.mem_rdata = (w == fw) ? instr : 16'($urandom);
      end

      @(negedge clock);
      mem_bus.mem_ack = 1'b0;
      X = xv;
      Y = yv;
      Z = zv;
      check_output("exec_instr", instruction, instr);
      check_output("exec_req", mem_bus.mem_req, 0);
      check_output("exec_xsel", x_sel, exp_x);
      check_output("exec_ysel", y_sel, instr[7:4]);
      check_output("exec_zsel", z_sel, instr[3:0]);

`ifdef NBBPU_CTRL_HALT_EN
      if (op == 4'hB) begin
         for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check_output("halt_flag", halted, 1);
            check_output("halt_req", mem_bus.mem_req, 0);
            check_output("halt_pc", PC, exp_pc);
            check_output("halt_we", reg_we, 0);
         end
         return;
      end
`endif

      if (mem_op) begin
         for (int w = 0; w <= mw; w++) begin
            @(negedge clock);
            check_output("data_req", mem_bus.mem_req, 1);
            check_output("data_addr", mem_bus.mem_addr, xv);
            check_output("data_we", mem_bus.mem_we, store);
            if (store) check_output("data_wdata", mem_bus.mem_wdata, yv);
            mem_bus.mem_ack   = (w == mw);
            mem_bus.mem_rdata = (w == mw) ? ld : 16'($urandom);
         end
      end

      @(negedge clock);
      mem_bus.mem_ack = 1'b0;
      check_output("wb_reg_we", reg_we, exp_we);
      check_output("wb_req", mem_bus.mem_req, 0);
      check_output("wb_halted", halted, 0);
      if (op == 4'hC) check_output("wb_read_data", read_data, ld);
      run = next_run;

      if (op == 4'h8) exp_pc = xv;
      else if (((op == 4'h9) || (op == 4'hA)) && zv[0]) exp_pc = xv;
      else exp_pc = exp_pc + 16'd1;

      if (!next_run) begin
         @(negedge clock);
         check_output("idle_req", mem_bus.mem_req, 0);
         check_output("idle_pc", PC, exp_pc);
         check_output("idle_reg_we", reg_we, 0);
      end
   endtask

   initial begin
      logic [15:0] ins;
      logic [3:0]  rop;
      checks = 0;
      errors = 0;
      reset = 1'b0;
      run   = 1'b0;
      X = '0;
      Y = '0;
      Z = '0;
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = '0;
      exp_pc = 16'h0000;

      repeat (3) @(negedge clock);
      check_output("rst_pc", PC, 16'h0000);
      check_output("rst_req", mem_bus.mem_req, 0);
      check_output("rst_reg_we", reg_we, 0);
      check_output("rst_instr", instruction, 16'h0000);
      check_output("rst_read_data", read_data, 16'h0000);
      check_output("rst_addr", mem_bus.mem_addr, 16'h0000);
      check_output("rst_halted", halted, 0);
      reset = 1'b1;
      @(negedge clock);
      check_output("idle_stays", mem_bus.mem_req, 0);
      run = 1'b1;

      apply_stimulus(16'h0123, 16'd5, 16'd7, 16'd12, 16'h0, 0, 0, 1'b1);
      apply_stimulus(16'hC103, 16'h0040, 16'h1111, 16'h0, 16'hBEEF, 2, 2, 1'b1);
      apply_stimulus(16'hD120, 16'h0080, 16'hCAFE, 16'h0, 16'h0, 1, 0, 1'b1);
      apply_stimulus(16'h9100, 16'h0020, 16'h0, 16'h0001, 16'h0, 0, 0, 1'b1);
      apply_stimulus(16'h9100, 16'h0050, 16'h0, 16'h0000, 16'h0, 0, 0, 1'b1);
      apply_stimulus(16'h8F00, 16'hFFFF, 16'h0, 16'h0022, 16'h0, 0, 0, 1'b1);
      apply_stimulus(16'h0123, 16'd1, 16'd2, 16'd3, 16'h0, 1, 0, 1'b1);
      apply_stimulus(16'hE512, 16'h00AA, 16'h0001, 16'h01AA, 16'h0, 0, 0, 1'b0);
      run = 1'b1;

      for (int i = 0; i < 40; i++) begin
         rop = 4'($urandom_range(0, 15));
`ifdef NBBPU_CTRL_HALT_EN
         if (rop == 4'hB) rop = 4'h0;
`endif
         ins = {rop, 12'($urandom)};
         apply_stimulus(ins, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                        $urandom_range(0, 3), $urandom_range(0, 3),
                        (i == 39) ? 1'b1 : ($urandom_range(0, 4) != 0));
         if (!run) run = 1'b1;
      end

      apply_stimulus(16'hB000, 16'h1234, 16'h0, 16'h0001, 16'h0, 0, 0, 1'b1);
`ifdef NBBPU_CTRL_HALT_EN
      #2;
      reset = 1'b0;
      #1;
      check_output("halt_rst_flag", halted, 0);
      check_output("halt_rst_pc", PC, 16'h0000);
      check_output("halt_rst_req", mem_bus.mem_req, 0);
      exp_pc = 16'h0000;
      @(negedge clock);
      reset = 1'b1;
      apply_stimulus(16'h0321, 16'd9, 16'd4, 16'd13, 16'h0, 0, 0, 1'b1);
`else
      apply_stimulus(16'h0321, 16'd9, 16'd4, 16'd13, 16'h0, 0, 0, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
